mode_scan_reader: RTL and testbench
===================================

Name: mode_scan_reader

Overview:
- Hardware mode finder that reads a dataset of LEN words starting at BASE from data memory through a request/acknowledge read port.
- Returns the most frequent value (mode) and its frequency.
- Acts as the memory-reader end of the data-memory interface and offloads the O(N^2) frequency-count loop from the MIPS32 core.
- Uses the same algorithm as the software version: strict greater-than update, so on a tie the first-encountered value wins.

Parameters:
DATA_W, 32, width of memory words and compared values
ADDR_W, 10, memory address width; addresses wrap modulo 2^ADDR_W
LEN_W, 8, width of dataset length and frequency counters

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; launches a scan when idle
base_addr  input  ADDR_W  first word address, sampled on accepted start
len  input  LEN_W  number of words to scan, sampled on accepted start
mem_req  output  1  read request; held high until acknowledged
mem_addr  output  ADDR_W  read address; stable while mem_req high
mem_ack  input  1  responder acknowledge; mem_rdata is valid in the same cycle
mem_rdata  input  DATA_W  read data
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse when the result is valid
mode  output  DATA_W  most frequent value; holds until the next accepted start
freq  output  LEN_W  occurrence count of mode; holds until the next accepted start

Behaviour:
- Reset (asynchronous, any time including mid-scan):
  - state=IDLE; busy, done, mem_req = 0.
  - mode, freq, mem_addr, and internal i, j, cnt, max, val_i = 0.
  - An in-flight request is abandoned; any ack arriving after reset is ignored.
- Start acceptance:
  - start is accepted only in IDLE; start while busy is ignored.
  - On accept: latch base_addr and len; clear i, max, mode, freq; set busy.
- len==0: IDLE -> DONE. done pulses on the next cycle with mode=0, freq=0.
- States:
  - IDLE: wait for start.
  - FETCH_I: mem_req=1, mem_addr=base+i. On ack: val_i<=mem_rdata, j<=0, cnt<=0, go to FETCH_J.
  - FETCH_J: mem_req=1, mem_addr=base+j. On ack:
    - if mem_rdata==val_i, cnt<=cnt+1.
    - if j==len-1, go to CMP; else j<=j+1 and stay in FETCH_J.
    - The count uses the compare result of the current beat, including the last beat.
  - CMP (1 cycle): if cnt>max then max<=cnt, mode<=val_i, freq<=cnt.
    - if i==len-1, go to DONE; else i<=i+1 and go to FETCH_I.
  - DONE (1 cycle): done=1, busy=0, then go to IDLE.
- Handshake:
  - mem_addr must not change while mem_req=1 and mem_ack=0.
  - mem_ack received while mem_req=0 is ignored.
  - Zero-wait responders (ack in the same cycle as req) are supported.
  - mem_req drops in CMP and DONE.
- Latency with a zero-wait responder: done asserts exactly len*(len+2)+1 cycles after the start cycle.
  - Example: len=8 gives 81 cycles.
- Arithmetic:
  - Address = (base+index) mod 2^ADDR_W; wrap past the top of memory is legal.
  - Comparison is full DATA_W equality; values are treated as unsigned bit patterns.
  - cnt and freq cannot overflow because cnt<=len.
- Outputs mode and freq update only in CMP.
  - Intermediate values are visible during busy.
  - Only the values at done are architecturally valid.

Test Plan:
- Zero-wait memory, mem[100..107]={1,2,3,4,8,6,7,8}, base=100, len=8 -> done after 81 cycles; mode=8, freq=2; exactly 72 acked reads.
- All distinct {10,20,30,40}, base=0, len=4 -> mode=10, freq=1. Tie {5,5,9,9} -> mode=5, freq=2 (first wins).
- Random 0-5 cycle ack delays, dataset {7,3,7,3,7}, base=1022, len=5 -> address wraps 1022,1023,0,1,2; mode=7, freq=3; mem_addr stable during every stall.
- len=0 -> done one cycle after start, mode=0, freq=0, mem_req never asserted. start pulsed while busy -> ignored, result unchanged.
- Assert rst during FETCH_J with mem_req high -> all outputs 0 immediately; a late mem_ack is ignored; a new start then completes correctly (mode=8, freq=2 on the first dataset).

Source files
------------

// File: rtl/mode_scan_reader.sv
// mode_scan_reader
// Finds the most frequent word (mode) and its occurrence count in a dataset
// of len words starting at base_addr, reading memory one word at a time
// through a request/acknowledge port. For every element i the whole dataset
// is re-read to count matches. The running best is replaced only on a strictly
// greater count, so on a tie the value encountered first is kept.
module mode_scan_reader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] mode,
  output logic [LEN_W-1:0]  freq
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH_I = 3'd1,
    S_FETCH_J = 3'd2,
    S_CMP     = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q,  base_d;
  logic [LEN_W-1:0]    len_q,   len_d;
  logic [LEN_W-1:0]    i_q,     i_d;
  logic [LEN_W-1:0]    j_q,     j_d;
  logic [LEN_W-1:0]    cnt_q,   cnt_d;
  logic [LEN_W-1:0]    max_q,   max_d;
  logic [DATA_W-1:0]   val_i_q, val_i_d;
  logic [DATA_W-1:0]   mode_q,  mode_d;
  logic [LEN_W-1:0]    freq_q,  freq_d;

  logic [LEN_W-1:0]    last_idx;
  logic                beat;
  logic                match;

  // Address of element idx relative to the base; wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] wrap_addr(
    input logic [ADDR_W-1:0] b,
    input logic [LEN_W-1:0]  idx
  );
    logic [ADDR_W-1:0] off;
    off = ADDR_W'(idx);
    return b + off;
  endfunction

  // Full-width unsigned equality of a fetched word against the current value.
  function automatic logic word_eq(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    return (a == b);
  endfunction

  // Index of the final element; only used once len_q is known non-zero.
  assign last_idx = len_q - LEN_W'(1);

  // A beat is a completed read: request outstanding and acknowledged together.
  assign beat  = mem_req & mem_ack;
  assign match = word_eq(mem_rdata, val_i_q);

  // Read port: request is high only in the fetch states, and the address is
  // derived purely from registered indices so it cannot move during a stall.
  always_comb begin
    mem_req  = 1'b0;
    mem_addr = wrap_addr(base_q, i_q);
    if (state_q == S_FETCH_I) begin
      mem_req  = 1'b1;
      mem_addr = wrap_addr(base_q, i_q);
    end else if (state_q == S_FETCH_J) begin
      mem_req  = 1'b1;
      mem_addr = wrap_addr(base_q, j_q);
    end
  end

  // Status outputs decoded directly from the state register.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_FETCH_I, S_FETCH_J, S_CMP: busy = 1'b1;
      S_DONE:                      done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  assign mode = mode_q;
  assign freq = freq_q;

  // Next-state and datapath update logic; every register holds by default.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    i_d     = i_q;
    j_d     = j_q;
    cnt_d   = cnt_q;
    max_d   = max_q;
    val_i_d = val_i_q;
    mode_d  = mode_q;
    freq_d  = freq_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d = base_addr;
          len_d  = len;
          i_d    = '0;
          max_d  = '0;
          mode_d = '0;
          freq_d = '0;
          // An empty dataset skips the scan entirely and reports zeros.
          if (len == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH_I;
          end
        end
      end

      S_FETCH_I: begin
        if (beat) begin
          val_i_d = mem_rdata;
          j_d     = '0;
          cnt_d   = '0;
          state_d = S_FETCH_J;
        end
      end

      S_FETCH_J: begin
        if (beat) begin
          // The final beat's compare is folded into cnt before CMP sees it.
          if (match) begin
            cnt_d = cnt_q + LEN_W'(1);
          end
          if (j_q == last_idx) begin
            state_d = S_CMP;
          end else begin
            j_d = j_q + LEN_W'(1);
          end
        end
      end

      S_CMP: begin
        // Strictly greater keeps the earliest value on ties.
        if (cnt_q > max_q) begin
          max_d  = cnt_q;
          mode_d = val_i_q;
          freq_d = cnt_q;
        end
        if (i_q == last_idx) begin
          state_d = S_DONE;
        end else begin
          i_d     = i_q + LEN_W'(1);
          state_d = S_FETCH_I;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any outstanding request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      cnt_q   <= '0;
      max_q   <= '0;
      val_i_q <= '0;
      mode_q  <= '0;
      freq_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      i_q     <= i_d;
      j_q     <= j_d;
      cnt_q   <= cnt_d;
      max_q   <= max_d;
      val_i_q <= val_i_d;
      mode_q  <= mode_d;
      freq_q  <= freq_d;
    end
  end

endmodule

// File: tb/tb_mode_scan_reader.sv
// Testbench for mode_scan_reader: memory responder with optional random
// stalls, stimulus pushing expected results into scoreboard queues, and a
// monitor that pops and compares on every read beat and every done pulse.
module tb_mode_scan_reader;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int LEN_W  = 8;

  logic              clk;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  len;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] mode;
  logic [LEN_W-1:0]  freq;

  mode_scan_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .mode      (mode),
    .freq      (freq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory responder ----------------
  logic [DATA_W-1:0] mem [0:1023];
  logic [2:0]        stall_cnt;
  logic              rand_mode;
  logic              ack_inject;

  initial stall_cnt = 3'd0;
  assign mem_rdata = mem[mem_addr];
  assign mem_ack   = (mem_req && (!rand_mode || stall_cnt == 3'd0)) || ack_inject;

  always @(posedge clk) begin
    if (mem_req && mem_ack)
      stall_cnt <= rand_mode ? 3'($urandom_range(0, 5)) : 3'd0;
    else if (mem_req && stall_cnt != 3'd0)
      stall_cnt <= stall_cnt - 3'd1;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [DATA_W-1:0] mode;
    logic [LEN_W-1:0]  freq;
    int                lat;
    int                reads;
    bit                req_exp;
  } exp_t;

  exp_t              sb[$];
  logic [ADDR_W-1:0] aq[$];

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int start_cyc   = 0;
  int reads_seen  = 0;
  int done_cnt    = 0;
  bit req_seen    = 1'b0;
  bit stall_v     = 1'b0;
  logic [ADDR_W-1:0] stall_addr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  always @(posedge clk) cyc++;

  // Monitor: samples on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    if (rst) begin
      stall_v = 1'b0;
    end else begin
      if (start && !busy && !done) begin
        start_cyc  = cyc;
        reads_seen = 0;
        req_seen   = 1'b0;
      end
      if (mem_req) req_seen = 1'b1;
      if (stall_v && mem_req)
        check("addr_stable", 64'(mem_addr), 64'(stall_addr));
      stall_v    = mem_req && !mem_ack;
      stall_addr = mem_addr;
      if (mem_req && mem_ack) begin
        reads_seen++;
        if (aq.size() == 0) begin
          check("unexpected_read", 64'(mem_addr), 64'hFFFF);
        end else begin
          logic [ADDR_W-1:0] ea;
          ea = aq.pop_front();
          check("read_addr", 64'(mem_addr), 64'(ea));
        end
      end
      if (done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          check("unexpected_done", 64'(done), 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("mode", 64'(mode), 64'(e.mode));
          check("freq", 64'(freq), 64'(e.freq));
          check("read_count", 64'(reads_seen), 64'(e.reads));
          check("addr_queue_drained", 64'(aq.size()), 64'd0);
          if (e.lat > 0) check("latency", 64'(cyc - start_cyc), 64'(e.lat));
          if (!e.req_exp) check("req_never_high", 64'(req_seen), 64'd0);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_scan(input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] l,
                          input logic [DATA_W-1:0] em, input logic [LEN_W-1:0] ef,
                          input int lat, input int reads, input bit poke);
    exp_t e;
    int   d0;
    e.mode = em; e.freq = ef; e.lat = lat; e.reads = reads; e.req_exp = (l != '0);
    sb.push_back(e);
    for (int i = 0; i < int'(l); i++) begin
      aq.push_back(b + ADDR_W'(i));
      for (int j = 0; j < int'(l); j++) aq.push_back(b + ADDR_W'(j));
    end
    d0 = done_cnt;
    base_addr = b; len = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; base_addr = '0; len = '0;
    for (int k = 0; k < 3000 && done_cnt == d0; k++) begin
      if (poke && k == 10) begin
        base_addr = 10'd0; len = 8'd4; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("done_within_budget", 64'(done_cnt - d0), 64'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0;
    rand_mode = 1'b0; ack_inject = 1'b0;
    for (int a = 0; a < 1024; a++) mem[a] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_mode", 64'(mode), 64'd0);
    check("rst_freq", 64'(freq), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Dataset 1, zero-wait: mode 8 (twice), 8*10+1 = 81 cycles, 8*9 = 72 reads.
    mem[100] = 1; mem[101] = 2; mem[102] = 3; mem[103] = 4;
    mem[104] = 8; mem[105] = 6; mem[106] = 7; mem[107] = 8;
    run_scan(10'd100, 8'd8, 32'd8, 8'd2, 81, 72, 1'b0);

    // All distinct: first value wins with count 1; 4*6+1 = 25 cycles.
    mem[0] = 10; mem[1] = 20; mem[2] = 30; mem[3] = 40;
    run_scan(10'd0, 8'd4, 32'd10, 8'd1, 25, 20, 1'b0);

    // Tie 5/9: first wins. A start pulse mid-scan must be ignored.
    mem[200] = 5; mem[201] = 5; mem[202] = 9; mem[203] = 9;
    run_scan(10'd200, 8'd4, 32'd5, 8'd2, 25, 20, 1'b1);

    // Wrapping addresses with random stalls: 1022,1023,0,1,2.
    rand_mode = 1'b1;
    mem[1022] = 7; mem[1023] = 3; mem[0] = 7; mem[1] = 3; mem[2] = 7;
    run_scan(10'd1022, 8'd5, 32'd7, 8'd3, 0, 30, 1'b0);
    rand_mode = 1'b0;

    // Empty dataset: done one cycle after start, zeros, no request.
    run_scan(10'd0, 8'd0, 32'd0, 8'd0, 1, 0, 1'b0);

    // Reset mid-scan during FETCH_J (after the first CMP updated mode).
    for (int i = 0; i < 8; i++) begin
      aq.push_back(10'd100 + ADDR_W'(i));
      for (int j = 0; j < 8; j++) aq.push_back(10'd100 + ADDR_W'(j));
    end
    base_addr = 10'd100; len = 8'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 500 && reads_seen < 12; k++) begin
      @(posedge clk); #1;
    end
    check("reached_fetch_j", 64'(reads_seen >= 12), 64'd1);
    check("pre_rst_mem_req", 64'(mem_req), 64'd1);
    rst = 1'b1;
    #1;
    check("async_rst_mem_req", 64'(mem_req), 64'd0);
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_mode", 64'(mode), 64'd0);
    check("async_rst_freq", 64'(freq), 64'd0);
    check("async_rst_mem_addr", 64'(mem_addr), 64'd0);
    aq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    ack_inject = 1'b1;
    @(posedge clk); #1;
    ack_inject = 1'b0;
    check("late_ack_busy", 64'(busy), 64'd0);
    check("late_ack_mem_req", 64'(mem_req), 64'd0);
    @(posedge clk); #1;
    check("late_ack_done", 64'(done), 64'd0);

    // Fresh scan after reset completes normally.
    run_scan(10'd100, 8'd8, 32'd8, 8'd2, 81, 72, 1'b0);

    repeat (2) @(posedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
